// File: rtl/gpu_pkg.sv
// Shared configuration, bank/row mapping and collector state for the banked register file.
package gpu_pkg;
  localparam int GPU_NUM_BANKS     = 4;
  localparam int GPU_NUM_WARPS     = 64;
  localparam int GPU_REGS_PER_WARP = 8;
  localparam int WARP_W            = $clog2(GPU_NUM_WARPS);
  localparam int REG_W             = $clog2(GPU_REGS_PER_WARP);

  typedef enum logic {IDLE, COLLECT} coll_state_e;

  function automatic int unsigned bank_of(input int unsigned w, input int unsigned r,
                                          input int unsigned nb = GPU_NUM_BANKS);
    return (w + r) % nb;
  endfunction

  // Row is the flat {warp, reg} index divided across the banks.
  function automatic int unsigned row_of(input int unsigned w, input int unsigned r,
                                         input int unsigned regs = GPU_REGS_PER_WARP,
                                         input int unsigned nb = GPU_NUM_BANKS);
    return (w * regs + r) / nb;
  endfunction
endpackage

// File: rtl/gpu_rf_bank.sv
// One register-file bank: asynchronous read, synchronous write, cleared by reset.
module gpu_rf_bank #(
  parameter int DEPTH  = 128,
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_row,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_row,
  output logic [DATA_W-1:0]        o_rd_data
);
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_wr_en) begin
      r_mem[i_wr_row] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_row];
endmodule

// File: rtl/gpu_banked_regfile.sv
// Banked per-warp register file with a two-operand collector and a one-entry response buffer.
module gpu_banked_regfile
  import gpu_pkg::*;
#(
  parameter int NUM_BANKS     = GPU_NUM_BANKS,
  parameter int NUM_WARPS     = GPU_NUM_WARPS,
  parameter int REGS_PER_WARP = GPU_REGS_PER_WARP,
  parameter int DATA_W        = 64,
  parameter int CNT_W         = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [$clog2(NUM_WARPS)-1:0]     req_warp,
  input  logic [$clog2(REGS_PER_WARP)-1:0] req_rs0,
  input  logic [$clog2(REGS_PER_WARP)-1:0] req_rs1,
  input  logic                             wr_en,
  input  logic [$clog2(NUM_WARPS)-1:0]     wr_warp,
  input  logic [$clog2(REGS_PER_WARP)-1:0] wr_rd,
  input  logic [DATA_W-1:0]                wr_data,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [DATA_W-1:0]                resp_data0,
  output logic [DATA_W-1:0]                resp_data1,
  output logic [CNT_W-1:0]                 conflict_cnt
);
  localparam int WID_W  = $clog2(NUM_WARPS);
  localparam int RID_W  = $clog2(REGS_PER_WARP);
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int DEPTH  = NUM_WARPS * REGS_PER_WARP / NUM_BANKS;
  localparam int ROW_W  = $clog2(DEPTH);

  coll_state_e       r_state;
  logic [WID_W-1:0]  r_warp;
  logic [RID_W-1:0]  r_rs0, r_rs1;
  logic [1:0]        r_pend;
  logic              r_same;
  logic [DATA_W-1:0] r_op0, r_op1;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_data0, r_resp_data1;
  logic [CNT_W-1:0]  r_cnt;

  logic [BANK_W-1:0] w_bank0, w_bank1, w_wr_bank;
  logic [ROW_W-1:0]  w_row0, w_row1, w_wr_row;
  logic [ROW_W-1:0]  w_rd_row  [NUM_BANKS];
  logic [DATA_W-1:0] w_rd_data [NUM_BANKS];
  logic              w_deny0, w_deny1, w_grant0, w_grant1, w_last, w_accept;
  logic [1:0]        w_ndeny;
  logic [CNT_W:0]    w_cnt_sum;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [DATA_W-1:0] w_sel0, w_sel1;

  assign w_bank0   = BANK_W'(bank_of(32'(r_warp), 32'(r_rs0), NUM_BANKS));
  assign w_bank1   = BANK_W'(bank_of(32'(r_warp), 32'(r_rs1), NUM_BANKS));
  assign w_wr_bank = BANK_W'(bank_of(32'(wr_warp), 32'(wr_rd), NUM_BANKS));
  assign w_row0    = ROW_W'(row_of(32'(r_warp), 32'(r_rs0), REGS_PER_WARP, NUM_BANKS));
  assign w_row1    = ROW_W'(row_of(32'(r_warp), 32'(r_rs1), REGS_PER_WARP, NUM_BANKS));
  assign w_wr_row  = ROW_W'(row_of(32'(wr_warp), 32'(wr_rd), REGS_PER_WARP, NUM_BANKS));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      // rs0 owns the bank read port whenever it is still pending there.
      assign w_rd_row[gi] = (r_pend[0] && (w_bank0 == BANK_W'(gi))) ? w_row0 : w_row1;
      gpu_rf_bank #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_bank (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (wr_en && (w_wr_bank == BANK_W'(gi))),
        .i_wr_row  (w_wr_row),
        .i_wr_data (wr_data),
        .i_rd_row  (w_rd_row[gi]),
        .o_rd_data (w_rd_data[gi])
      );
    end
  endgenerate

  // A write to the bank beats any read; rs0 beats rs1 on a shared bank.
  assign w_deny0  = r_pend[0] && wr_en && (w_wr_bank == w_bank0);
  assign w_deny1  = r_pend[1] && ((wr_en && (w_wr_bank == w_bank1)) ||
                                  (r_pend[0] && (w_bank0 == w_bank1)));
  assign w_grant0 = r_pend[0] && !w_deny0;
  assign w_grant1 = r_pend[1] && !w_deny1;
  assign w_last   = (r_state == COLLECT) && !w_deny0 && !w_deny1;
  assign w_ndeny  = {1'b0, w_deny0} + {1'b0, w_deny1};

  assign w_cnt_sum  = {1'b0, r_cnt} + {{(CNT_W-1){1'b0}}, w_ndeny};
  assign w_cnt_next = w_cnt_sum[CNT_W] ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];

  assign w_sel0 = w_grant0 ? w_rd_data[w_bank0] : r_op0;
  assign w_sel1 = r_same ? w_sel0 : (w_grant1 ? w_rd_data[w_bank1] : r_op1);

  assign req_ready = (r_state == IDLE) && (!r_resp_valid || resp_ready);
  assign w_accept  = req_valid && req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_warp       <= '0;
      r_rs0        <= '0;
      r_rs1        <= '0;
      r_pend       <= '0;
      r_same       <= 1'b0;
      r_op0        <= '0;
      r_op1        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data0 <= '0;
      r_resp_data1 <= '0;
      r_cnt        <= '0;
    end else begin
      r_cnt <= w_cnt_next;
      if (w_grant0) r_op0 <= w_rd_data[w_bank0];
      if (w_grant1) r_op1 <= w_rd_data[w_bank1];
      if (r_resp_valid && resp_ready) r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_warp  <= req_warp;
            r_rs0   <= req_rs0;
            r_rs1   <= req_rs1;
            r_pend  <= {req_rs0 != req_rs1, 1'b1};
            r_same  <= (req_rs0 == req_rs1);
            r_state <= COLLECT;
          end
        end
        COLLECT: begin
          r_pend <= {w_deny1, w_deny0};
          if (w_last) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b1;
            r_resp_data0 <= w_sel0;
            r_resp_data1 <= w_sel1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign resp_valid   = r_resp_valid;
  assign resp_data0   = r_resp_data0;
  assign resp_data1   = r_resp_data1;
  assign conflict_cnt = r_cnt;
endmodule
